// File: rtl/uart_pkg.sv
// Shared UART definitions: baud table, frame/parity/stop encodings and the serializer state set.
// Used by both the transmit and receive halves.
package uart_pkg;

    localparam int unsigned DIV_W = 20;

    localparam int unsigned BAUD_TABLE [16] = '{
        200, 300, 600, 1200, 1800, 2400, 4800, 9600,
        19200, 28800, 38400, 57600, 76800, 115200, 230400, 460800
    };

    typedef enum logic [1:0] {
        FRAME_5 = 2'b00,
        FRAME_6 = 2'b01,
        FRAME_7 = 2'b10,
        FRAME_8 = 2'b11
    } frame_t;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    typedef enum logic {
        STOP_1 = 1'b0,
        STOP_2 = 1'b1
    } stop_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic logic [3:0] frame_bits(input frame_t f);
        return 4'd5 + {2'b00, f};
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter: restart latches the divisor, then o_tick fires
// every i_div clocks while enabled.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_restart,
    input  logic             i_en,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;

    assign o_tick = i_en && (r_cnt == '0);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt <= '0;
            r_div <= '0;
        end else if (i_restart) begin
            r_div <= i_div;
            r_cnt <= i_div - DIV_W'(1);
        end else if (o_tick) begin
            r_cnt <= r_div - DIV_W'(1);
        end else if (i_en) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All framing config and the bit period are captured when a request is accepted.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       on,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic [3:0] baud_sel,
    input  logic       stop_type,
    input  logic [1:0] parity_type,
    input  logic [1:0] frame_type,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic             r_stop_cnt;
    logic             r_par;
    frame_t           r_frame;
    parity_t          r_parity;
    stop_t            r_stop;

    logic             w_accept;
    logic             w_tick;
    logic             w_last_data;
    logic             w_par_en;
    logic             w_par_bit;
    logic             w_tx_next;
    logic             w_done_next;
    logic [DIV_W-1:0] w_div_tab [16];

    for (genvar g = 0; g < 16; g++) begin : g_div
        assign w_div_tab[g] = DIV_W'(CLK_FREQ_HZ / BAUD_TABLE[g]);
    end

    assign w_accept    = tx_start && on && (r_state == IDLE);
    assign w_last_data = (r_bit_cnt == 3'(frame_bits(r_frame) - 4'd1));
    assign w_par_en    = (r_parity == PAR_EVEN) || (r_parity == PAR_ODD);
    // r_par holds the XOR of the bits already completed; fold in the final one here.
    assign w_par_bit   = r_par ^ r_shift[0] ^ (r_parity == PAR_ODD);

    uart_baud_gen u_baud (
        .clk       (clk),
        .arst      (arst),
        .i_div     (w_div_tab[baud_sel]),
        .i_restart (w_accept),
        .i_en      (r_state != IDLE),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (w_accept) begin
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (!w_last_data) begin
                        w_tx_next = r_shift[1];
                    end else if (w_par_en) begin
                        w_state_next = PARITY;
                        w_tx_next    = w_par_bit;
                    end else begin
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                    w_tx_next    = 1'b1;
                end
            end
            STOP: begin
                w_tx_next = 1'b1;
                if (w_tick && ((r_stop == STOP_1) || r_stop_cnt)) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_frame    <= FRAME_5;
            r_parity   <= PAR_NONE;
            r_stop     <= STOP_1;
        end else begin
            r_tx   <= w_tx_next;
            r_done <= w_done_next;
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_shift    <= tx_data;
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                r_par      <= 1'b0;
                r_frame    <= frame_t'(frame_type);
                r_parity   <= parity_t'(parity_type);
                r_stop     <= stop_t'(stop_type);
            end else begin
                if (w_done_next) begin
                    r_busy <= 1'b0;
                end
                if (w_tick && (r_state == DATA)) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_par     <= r_par ^ r_shift[0];
                end
                if (w_tick && (r_state == STOP)) begin
                    r_stop_cnt <= 1'b1;
                end
            end
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: expected frames are queued at request time and
// checked cycle-accurately (first/middle/last clock of every bit) by a line monitor.
module tb_uart_tx_core;

    localparam int unsigned CLK_HZ = 4_000_000;
    localparam int unsigned BAUD [16] = '{
        200, 300, 600, 1200, 1800, 2400, 4800, 9600,
        19200, 28800, 38400, 57600, 76800, 115200, 230400, 460800
    };

    typedef struct {
        logic [11:0] bits;
        int          n;
        int          div;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       on = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = '0;
    logic [3:0] baud_sel = '0;
    logic       stop_type = 1'b0;
    logic [1:0] parity_type = '0;
    logic [1:0] frame_type = '0;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;
    exp_t sb [$];

    uart_tx_core #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .arst        (arst),
        .on          (on),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .baud_sel    (baud_sel),
        .stop_type   (stop_type),
        .parity_type (parity_type),
        .frame_type  (frame_type),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t build(input logic [7:0] d, input logic [3:0] b,
                                   input logic [1:0] f, input logic [1:0] p, input logic s);
        exp_t e;
        int   nb;
        logic par;
        nb     = 5 + int'(f);
        par    = 1'b0;
        e.bits = '1;
        e.n    = 0;
        e.bits[e.n] = 1'b0;
        e.n++;
        for (int i = 0; i < nb; i++) begin
            e.bits[e.n] = d[i];
            par = par ^ d[i];
            e.n++;
        end
        if (p == 2'b01) begin
            e.bits[e.n] = par;
            e.n++;
        end else if (p == 2'b10) begin
            e.bits[e.n] = ~par;
            e.n++;
        end
        e.bits[e.n] = 1'b1;
        e.n++;
        if (s) begin
            e.bits[e.n] = 1'b1;
            e.n++;
        end
        e.div = int'(CLK_HZ / BAUD[b]);
        return e;
    endfunction

    task automatic send(input logic [7:0] d, input logic [3:0] b, input logic [1:0] f,
                        input logic [1:0] p, input logic s, input bit push);
        tx_data     = d;
        baud_sel    = b;
        frame_type  = f;
        parity_type = p;
        stop_type   = s;
        tx_start    = 1'b1;
        if (push) sb.push_back(build(d, b, f, p, s));
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (tx_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(tx_done), 32'd1);
    endtask

    initial begin : monitor
        exp_t e;
        int   ph;
        @(negedge clk);
        forever begin
            while (!(mon_en && tx === 1'b0)) @(negedge clk);
            if (sb.size() == 0) begin
                check("unexpected_frame", 32'(sb.size()), 32'd1);
                while (tx === 1'b0) @(negedge clk);
            end else begin
                e = sb.pop_front();
                for (int k = 0; k < e.n * e.div; k++) begin
                    ph = k % e.div;
                    if (ph == 0 || ph == e.div / 2 || ph == e.div - 1)
                        check($sformatf("bit%0d_ph%0d", k / e.div, ph), 32'(tx), 32'(e.bits[k / e.div]));
                    if (ph == 0)
                        check("busy_in_frame", 32'(tx_busy), 32'd1);
                    @(negedge clk);
                end
                check("done_pulse", 32'(tx_done), 32'd1);
                check("busy_clear", 32'(tx_busy), 32'd0);
                check("tx_idle_after", 32'(tx), 32'd1);
                @(negedge clk);
                check("done_single", 32'(tx_done), 32'd0);
            end
        end
    end

    initial begin : stimulus
        #12;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        on   = 1'b1;
        repeat (3) @(negedge clk);

        // async reset pulse while idle
        #2 arst = 1'b1;
        #1;
        check("idle_rst_tx", 32'(tx), 32'd1);
        check("idle_rst_busy", 32'(tx_busy), 32'd0);
        check("idle_rst_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 9600, 0xA5, with start-bit latency
        send(8'hA5, 4'd7, 2'b11, 2'b00, 1'b0, 1'b1);
        check("start_latency", 32'(tx), 32'd0);
        check("busy_on_accept", 32'(tx_busy), 32'd1);
        wait_done(6000);

        // 8E1 and 8O1
        send(8'hA5, 4'd13, 2'b11, 2'b01, 1'b0, 1'b1);
        wait_done(6000);
        send(8'hA5, 4'd13, 2'b11, 2'b10, 1'b0, 1'b1);
        wait_done(6000);

        // 5-bit even parity, two stop bits; upper data bits ignored
        send(8'hF3, 4'd13, 2'b00, 2'b01, 1'b1, 1'b1);
        wait_done(6000);

        // held start and on dropping mid-frame leave the frame untouched
        send(8'h3C, 4'd13, 2'b11, 2'b00, 1'b0, 1'b1);
        repeat (3 * 34) @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        baud_sel = 4'd0;
        repeat (34) @(negedge clk);
        on = 1'b0;
        repeat (34) @(negedge clk);
        tx_start = 1'b0;
        wait_done(6000);
        repeat (2) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        check("off_no_start_tx", 32'(tx), 32'd1);
        check("off_no_start_busy", 32'(tx_busy), 32'd0);
        on = 1'b1;

        // start coincident with done
        send(8'h96, 4'd14, 2'b11, 2'b10, 1'b1, 1'b1);
        wait_done(6000);
        send(8'h5A, 4'd13, 2'b10, 2'b00, 1'b0, 1'b1);
        check("b2b_start", 32'(tx), 32'd0);
        wait_done(6000);

        // 460800: period latched, baud/config changes mid-frame ignored
        send(8'hC7, 4'd15, 2'b11, 2'b01, 1'b1, 1'b1);
        repeat (2 * 8) @(negedge clk);
        baud_sel    = 4'd0;
        frame_type  = 2'b00;
        parity_type = 2'b10;
        stop_type   = 1'b0;
        wait_done(6000);
        repeat (2) @(negedge clk);

        // reset in the middle of a data bit aborts the frame
        mon_en = 1'b0;
        send(8'h00, 4'd13, 2'b11, 2'b00, 1'b0, 1'b0);
        repeat (2 * 34 + 17) @(negedge clk);
        check("mid_data_tx", 32'(tx), 32'd0);
        check("mid_data_busy", 32'(tx_busy), 32'd1);
        #2 arst = 1'b1;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        repeat (40) @(negedge clk);
        check("no_resume_tx", 32'(tx), 32'd1);
        check("no_resume_busy", 32'(tx_busy), 32'd0);
        mon_en = 1'b1;
        @(negedge clk);
        send(8'h81, 4'd13, 2'b11, 2'b00, 1'b0, 1'b1);
        wait_done(6000);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
